// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Integer register file with NRD combinational read ports, one write port,
//   optional same-cycle write-to-read forwarding, and a per-register pending
//   write counter. Issue reserves a destination register. Writeback writes the
//   data and, with wr_rel, releases one reservation. Decode stalls on rd_busy.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   rd_addr    in   NRD*AW    read addresses, port i at [i*AW +: AW]
//   rd_data    out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//   rd_busy    out  NRD       register on port i has pending write(s)
//   wr_en      in   write strobe
//   wr_addr    in   write address
//   wr_data    in   write data
//   wr_rel     in   with wr_en: release one reservation on wr_addr
//   rsv_valid  in   issue requests a reservation
//   rsv_addr   in   register to reserve
//   rsv_ready  out  reservation can be accepted this cycle
//   flush      in   synchronous clear of all pending counters
//   sb_err     out  sticky: a release hit a non-pending register
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int CNTW     = 2,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                wr_rel,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ready,
    input  logic                flush,
    output logic                sb_err
);

    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1'b1);
    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};

    logic [XLEN-1:0] r_regs [NREGS];
    logic [CNTW-1:0] r_cnt  [NREGS];
    logic [CNTW-1:0] w_cnt_nxt [NREGS];
    logic            r_sb_err;

    logic            w_wr_ok;
    logic            w_rel;
    logic            w_acc;
    logic            w_same;
    logic            w_rsv_full;
    logic            w_rel_cnt_zero;
    logic [AW-1:0]   w_rd_a;

    // Address decodes at the boundary of the array (non-power-of-two NREGS)
    function automatic logic f_in_range(input logic [AW-1:0] a);
        return (32'(a) < 32'(NREGS));
    endfunction

    // Register 0 is hardwired when ZERO_REG is set
    function automatic logic f_is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == {AW{1'b0}});
    endfunction

    // Only tracked registers store data and carry a pending counter
    function automatic logic f_tracked(input logic [AW-1:0] a);
        return f_in_range(a) && !f_is_zero(a);
    endfunction

    assign w_wr_ok        = wr_en && f_tracked(wr_addr);
    assign w_rel          = w_wr_ok && wr_rel;
    assign w_rsv_full     = f_tracked(rsv_addr) && (r_cnt[rsv_addr] == CNT_MAX);
    // A release to the same register in this cycle frees the slot just in time
    assign rsv_ready      = !(w_rsv_full && !(w_rel && (wr_addr == rsv_addr)));
    assign w_acc          = rsv_valid && rsv_ready && f_tracked(rsv_addr);
    assign w_same         = w_acc && w_rel && (wr_addr == rsv_addr);
    assign w_rel_cnt_zero = w_rel && (r_cnt[wr_addr] == CNT_ZERO);
    assign sb_err         = r_sb_err;

    // Next-state of every pending counter; flush wins over accept/release
    always_comb begin
        for (int j = 0; j < NREGS; j++) begin
            w_cnt_nxt[j] = r_cnt[j];
            if (flush) begin
                w_cnt_nxt[j] = CNT_ZERO;
            end else if (w_same && (rsv_addr == AW'(j))) begin
                w_cnt_nxt[j] = r_cnt[j];
            end else if (w_acc && (rsv_addr == AW'(j))) begin
                w_cnt_nxt[j] = r_cnt[j] + CNT_ONE;
            end else if (w_rel && (wr_addr == AW'(j)) && (r_cnt[j] != CNT_ZERO)) begin
                w_cnt_nxt[j] = r_cnt[j] - CNT_ONE;
            end else begin
                w_cnt_nxt[j] = r_cnt[j];
            end
        end
    end

    // Pending counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < NREGS; j++) begin
                r_cnt[j] <= CNT_ZERO;
            end
        end else begin
            for (int j = 0; j < NREGS; j++) begin
                r_cnt[j] <= w_cnt_nxt[j];
            end
        end
    end

    // Register storage; writes ignore flush and busy state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < NREGS; j++) begin
                r_regs[j] <= {XLEN{1'b0}};
            end
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Sticky error: release of a register with nothing pending. A reservation
    // accepted on the same register in the same cycle covers the release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sb_err <= 1'b0;
        end else if (!flush && w_rel_cnt_zero && !w_same) begin
            r_sb_err <= 1'b1;
        end
    end

    // Read ports with optional forwarding of the in-flight write
    always_comb begin
        rd_data = {(NRD*XLEN){1'b0}};
        rd_busy = {NRD{1'b0}};
        w_rd_a  = {AW{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            w_rd_a = rd_addr[i*AW +: AW];
            if (!f_tracked(w_rd_a)) begin
                rd_data[i*XLEN +: XLEN] = {XLEN{1'b0}};
                rd_busy[i]              = 1'b0;
            end else begin
                if ((BYPASS != 0) && w_wr_ok && (wr_addr == w_rd_a)) begin
                    rd_data[i*XLEN +: XLEN] = wr_data;
                end else begin
                    rd_data[i*XLEN +: XLEN] = r_regs[w_rd_a];
                end
                // The last outstanding write completing now clears busy early
                if ((BYPASS != 0) && w_rel && (wr_addr == w_rd_a) &&
                    (r_cnt[w_rd_a] == CNT_ONE)) begin
                    rd_busy[i] = 1'b0;
                end else begin
                    rd_busy[i] = (r_cnt[w_rd_a] != CNT_ZERO);
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_rel;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic        flush;
    logic        sb_err;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Reference model state: register contents, outstanding count, error flag
    logic [31:0] mregs [32] = '{default: 32'h0};
    int          mcnt  [32] = '{default: 0};
    bit          merr = 1'b0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_rel    (wr_rel),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .flush     (flush),
        .sb_err    (sb_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_rel();
        return wr_en && wr_rel && (wr_addr != 5'd0);
    endfunction

    function automatic bit m_ready();
        return (rsv_addr == 5'd0) || (mcnt[rsv_addr] < 3) ||
               (m_rel() && (wr_addr == rsv_addr));
    endfunction

    function automatic bit m_acc();
        return rsv_valid && m_ready() && (rsv_addr != 5'd0);
    endfunction

    // Model update at each clock edge, cleared by reset
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 32; k++) begin
                mregs[k] <= 32'h0;
                mcnt[k]  <= 0;
            end
            merr <= 1'b0;
        end else begin
            if (wr_en && (wr_addr != 5'd0)) mregs[wr_addr] <= wr_data;
            if (flush) begin
                for (int k = 0; k < 32; k++) mcnt[k] <= 0;
            end else if (!(m_acc() && m_rel() && (wr_addr == rsv_addr))) begin
                if (m_acc()) mcnt[rsv_addr] <= mcnt[rsv_addr] + 1;
                if (m_rel()) begin
                    if (mcnt[wr_addr] == 0) merr <= 1'b1;
                    else mcnt[wr_addr] <= mcnt[wr_addr] - 1;
                end
            end
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin : cmp
        logic [4:0]  a;
        logic [31:0] ed;
        logic        eb;
        if (reset_n && chk_en) begin
            for (int p = 0; p < 2; p++) begin
                a = rd_addr[p*5 +: 5];
                if (a == 5'd0) begin
                    ed = 32'h0;
                    eb = 1'b0;
                end else begin
                    ed = (wr_en && (wr_addr == a)) ? wr_data : mregs[a];
                    eb = (mcnt[a] != 0) &&
                         !(m_rel() && (wr_addr == a) && (mcnt[a] == 1));
                end
                chk("cmp_rd_data", 64'(rd_data[p*32 +: 32]), 64'(ed));
                chk("cmp_rd_busy", 64'(rd_busy[p]), 64'(eb));
            end
            chk("cmp_rsv_ready", 64'(rsv_ready), 64'(m_ready()));
            chk("cmp_sb_err", 64'(sb_err), 64'(merr));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        wr_en = 1'b0; wr_rel = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
        rsv_valid = 1'b0; rsv_addr = 5'd0; flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        rd_addr = 10'd0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk_en = 1'b1;

        // 1. Post-reset sweep of every address on both ports
        for (int a = 0; a < 32; a++) begin
            tick();
            rd_addr = {5'(31 - a), 5'(a)};
            #2;
            chk("reset_rd_data", rd_data, 64'h0);
            chk("reset_rd_busy", 64'(rd_busy), 64'h0);
        end
        chk("reset_rsv_ready", 64'(rsv_ready), 64'h1);
        chk("reset_sb_err", 64'(sb_err), 64'h0);

        // 2. Forwarding of r5, zero-register writes ignored
        tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        rd_addr = {5'd5, 5'd0};
        #2 chk("bypass_r5", 64'(rd_data[63:32]), 64'hDEADBEEF);
        tick(); idle();
        #2 chk("stored_r5", 64'(rd_data[63:32]), 64'hDEADBEEF);
        tick();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        #2 chk("r0_bypass", 64'(rd_data[31:0]), 64'h0);
        tick(); idle();
        #2 chk("r0_stored", 64'(rd_data[31:0]), 64'h0);

        // 3. Saturate r7, release, then reserve+release at full count
        for (int k = 0; k < 3; k++) begin
            tick(); rsv_valid = 1'b1; rsv_addr = 5'd7;
        end
        tick(); rsv_valid = 1'b0; rd_addr = {5'd0, 5'd7};
        #2;
        chk("r7_busy_full", 64'(rd_busy[0]), 64'h1);
        chk("r7_not_ready", 64'(rsv_ready), 64'h0);
        tick(); wr_en = 1'b1; wr_rel = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        #2;
        chk("r7_ready_on_rel", 64'(rsv_ready), 64'h1);
        chk("r7_busy_on_rel", 64'(rd_busy[0]), 64'h1);
        chk("r7_fwd_on_rel", 64'(rd_data[31:0]), 64'h77);
        tick(); wr_en = 1'b0; wr_rel = 1'b0;
        #2 chk("r7_ready_cnt2", 64'(rsv_ready), 64'h1);
        tick(); rsv_valid = 1'b1;
        tick(); wr_en = 1'b1; wr_rel = 1'b1; wr_addr = 5'd7; wr_data = 32'h78;
        #2 chk("r7_ready_same", 64'(rsv_ready), 64'h1);
        tick(); idle(); rsv_addr = 5'd7;
        #2;
        chk("r7_still_full", 64'(rsv_ready), 64'h0);
        chk("r7_still_busy", 64'(rd_busy[0]), 64'h1);

        // 4. Reserve r9, then write+release while reading it
        tick(); rsv_valid = 1'b1; rsv_addr = 5'd9;
        tick(); rsv_valid = 1'b0;
        wr_en = 1'b1; wr_rel = 1'b1; wr_addr = 5'd9; wr_data = 32'hCAFEF00D;
        rd_addr = {5'd0, 5'd9};
        #2;
        chk("r9_busy_rel", 64'(rd_busy[0]), 64'h0);
        chk("r9_fwd", 64'(rd_data[31:0]), 64'hCAFEF00D);
        tick(); idle();
        #2;
        chk("r9_busy_after", 64'(rd_busy[0]), 64'h0);
        chk("r9_data_after", 64'(rd_data[31:0]), 64'hCAFEF00D);
        chk("r9_no_err", 64'(sb_err), 64'h0);

        // 5. Flush clears everything, including a reservation in the same cycle
        tick(); rsv_valid = 1'b1; rsv_addr = 5'd3;
        tick(); rsv_addr = 5'd4;
        tick(); rsv_valid = 1'b0; rd_addr = {5'd4, 5'd3};
        #2 chk("r3r4_busy", 64'(rd_busy), 64'h3);
        tick(); flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd6;
        tick(); idle(); rd_addr = {5'd6, 5'd3};
        #2 chk("flush_busy", 64'(rd_busy), 64'h0);
        tick(); wr_en = 1'b1; wr_rel = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #2 chk("err_before", 64'(sb_err), 64'h0);
        tick(); idle();
        #2 chk("err_after", 64'(sb_err), 64'h1);

        // 6. Asynchronous reset mid-sequence with state pending
        tick(); rsv_valid = 1'b1; rsv_addr = 5'd10;
        tick(); rsv_valid = 1'b0; rd_addr = {5'd10, 5'd5};
        #2;
        chk("pre_rst_busy", 64'(rd_busy[1]), 64'h1);
        chk("pre_rst_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_rd_data", rd_data, 64'h0);
        chk("rst_rd_busy", 64'(rd_busy), 64'h0);
        chk("rst_sb_err", 64'(sb_err), 64'h0);
        chk("rst_rsv_ready", 64'(rsv_ready), 64'h1);
        tick(); reset_n = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
